// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage SRAM responder, the MEM stage and the SRAM model.
// Holds the controller state encoding, the SRAM base mapping and the pad data width.
package mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } sram_state_t;

  localparam int unsigned ADDR_BASE   = 1024;
  localparam int unsigned SRAM_DATA_W = 16;

endpackage

// File: rtl/mem_sram_controller.sv
// Serves 32-bit MEM-stage word reads/writes from a 16-bit asynchronous SRAM,
// one half-word access per phase, stalling the pipeline via ready while busy.
module mem_sram_controller #(
  parameter int unsigned SRAM_ADDR_W   = 18,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned ADDR_BASE     = mem_pkg::ADDR_BASE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mem_r_en,
  input  logic                            mem_w_en,
  input  logic [31:0]                     addr,
  input  logic [31:0]                     wr_data,
  output logic [31:0]                     rd_data,
  output logic                            ready,
  output logic [SRAM_ADDR_W-1:0]          sram_addr,
  output logic [mem_pkg::SRAM_DATA_W-1:0] sram_dq_out,
  output logic                            sram_dq_oe,
  input  logic [mem_pkg::SRAM_DATA_W-1:0] sram_dq_in,
  output logic                            sram_we_n,
  output logic                            sram_oe_n
);
  import mem_pkg::*;

  localparam int unsigned      CNT_W    = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  generate
    if (ACCESS_CYCLES < 2) begin : g_bad_access_cycles
      $error("mem_sram_controller: ACCESS_CYCLES must be at least 2");
    end
  endgenerate

  sram_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            rd_data_q, rd_data_d;
  logic [31:0]            offset;
  logic [SRAM_ADDR_W-2:0] word;
  logic                   last;
  logic                   unused_addr_bits;

  // Word index relative to the SRAM window; anything above capacity wraps by truncation.
  assign offset           = addr - 32'(ADDR_BASE);
  assign word             = offset[SRAM_ADDR_W:2];
  assign unused_addr_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};
  assign last             = (cnt_q == CNT_LAST);
  assign rd_data          = rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    rd_data_d   = rd_data_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;

    case (state_q)
      S_IDLE: begin
        ready = !(mem_r_en | mem_w_en);
        if (mem_w_en) begin
          state_d = S_WR_LO;
        end else if (mem_r_en) begin
          state_d = S_RD_LO;
        end
      end

      S_RD_LO, S_RD_HI: begin
        sram_oe_n = 1'b0;
        sram_addr = {word, state_q == S_RD_HI};
        cnt_d     = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          if (state_q == S_RD_LO) begin
            rd_data_d[15:0] = sram_dq_in;
            state_d         = S_RD_HI;
          end else begin
            rd_data_d[31:16] = sram_dq_in;
            state_d          = S_DONE;
          end
        end
      end

      S_WR_LO, S_WR_HI: begin
        sram_dq_oe  = 1'b1;
        sram_addr   = {word, state_q == S_WR_HI};
        sram_dq_out = (state_q == S_WR_HI) ? wr_data[31:16] : wr_data[15:0];
        // Strobe released on the final cycle so address and data hold past the write edge.
        sram_we_n   = last;
        cnt_d       = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          state_d = (state_q == S_WR_LO) ? S_WR_HI : S_DONE;
        end
      end

      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      ready = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_sram_controller.sv
// Directed bench for mem_sram_controller: a 2-cycle instance backed by a small SRAM
// model and a 4-cycle instance whose pad data is driven per cycle by the bench.
module tb_mem_sram_controller;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, r_en, w_en, ready, dq_oe, we_n, oe_n;
  logic [31:0] addr, wr_data, rd_data;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;

  logic        r_en4, w_en4, ready4, dq_oe4, we_n4, oe_n4;
  logic [31:0] addr4, wr_data4, rd_data4;
  logic [17:0] sram_addr4;
  logic [15:0] dq_out4, dq_in4;

  logic [15:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [15:0] pre_data;

  int errors = 0;
  int checks = 0;

  mem_sram_controller #(.SRAM_ADDR_W(18), .ACCESS_CYCLES(2), .ADDR_BASE(1024)) u_dut (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(dq_out), .sram_dq_oe(dq_oe), .sram_dq_in(dq_in),
    .sram_we_n(we_n), .sram_oe_n(oe_n)
  );

  mem_sram_controller #(.SRAM_ADDR_W(18), .ACCESS_CYCLES(4), .ADDR_BASE(1024)) u_dut4 (
    .clk(clk), .rst(rst), .mem_r_en(r_en4), .mem_w_en(w_en4), .addr(addr4),
    .wr_data(wr_data4), .rd_data(rd_data4), .ready(ready4), .sram_addr(sram_addr4),
    .sram_dq_out(dq_out4), .sram_dq_oe(dq_oe4), .sram_dq_in(dq_in4),
    .sram_we_n(we_n4), .sram_oe_n(oe_n4)
  );

  // Behavioural SRAM: writes on the clock edge while the strobe is low, reads combinationally.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!we_n && dq_oe) mem[sram_addr[5:0]] <= dq_out;
  end
  assign dq_in = !oe_n ? mem[sram_addr[5:0]] : 16'h0000;

  task automatic test_reset;
    rst = 1'b1; r_en = 1'b1; w_en = 1'b0; addr = 32'd1024; wr_data = '0;
    r_en4 = 1'b0; w_en4 = 1'b0; addr4 = 32'd1024; wr_data4 = '0; dq_in4 = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    @(negedge clk); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_with_req: got %b expected 1", ready); end
    @(negedge clk); r_en = 1'b0; rst = 1'b0; #1;
    checks++; if ({we_n, oe_n, dq_oe} !== 3'b110) begin errors++; $display("FAIL reset_strobes: got %b expected 110", {we_n, oe_n, dq_oe}); end
    checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL reset_sram_addr: got %h expected 0", sram_addr); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    checks++; if (ready !== 1'b1 || ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b%b expected 11", ready, ready4); end
  endtask

  task automatic test_write_read;
    logic [4:1]  rdy_v, we_v, oe_v, dqoe_v;
    logic [17:0] a_lo, a_hi;
    @(negedge clk); w_en = 1'b1; addr = 32'd1032; wr_data = 32'hDEADBEEF; #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL wr_accept_ready: got %b expected 0", ready); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      rdy_v[i] = ready; we_v[i] = we_n; oe_v[i] = oe_n; dqoe_v[i] = dq_oe;
      if (i == 1) a_lo = sram_addr;
      if (i == 3) a_hi = sram_addr;
    end
    checks++; if (rdy_v !== 4'b0000) begin errors++; $display("FAIL wr_ready_low: got %b expected 0000", rdy_v); end
    checks++; if (we_v !== 4'b1010) begin errors++; $display("FAIL wr_we_n_pulse: got %b expected 1010", we_v); end
    checks++; if (dqoe_v !== 4'b1111) begin errors++; $display("FAIL wr_dq_oe: got %b expected 1111", dqoe_v); end
    checks++; if (oe_v !== 4'b1111) begin errors++; $display("FAIL wr_oe_n: got %b expected 1111", oe_v); end
    checks++; if (a_lo !== 18'd4 || a_hi !== 18'd5) begin errors++; $display("FAIL wr_sram_addr: got %0d/%0d expected 4/5", a_lo, a_hi); end
    @(negedge clk); w_en = 1'b0; #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wr_done_ready: got %b expected 1", ready); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL wr_keeps_rd_data: got %h expected 0", rd_data); end
    checks++; if (mem[4] !== 16'hBEEF || mem[5] !== 16'hDEAD) begin errors++; $display("FAIL wr_sram_content: got %h %h expected beef dead", mem[4], mem[5]); end

    @(negedge clk); r_en = 1'b1; addr = 32'd1032; #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rd_accept_ready: got %b expected 0", ready); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      rdy_v[i] = ready; we_v[i] = we_n; oe_v[i] = oe_n; dqoe_v[i] = dq_oe;
    end
    checks++; if ({rdy_v, oe_v} !== 8'h00) begin errors++; $display("FAIL rd_ready_oe_n: got %b %b expected 0000 0000", rdy_v, oe_v); end
    checks++; if ({we_v, dqoe_v} !== 8'hF0) begin errors++; $display("FAIL rd_we_n_dq_oe: got %b %b expected 1111 0000", we_v, dqoe_v); end
    @(negedge clk); r_en = 1'b0; #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rd_done_ready: got %b expected 1", ready); end
    checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_word: got %h expected deadbeef", rd_data); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] pv [4];
    logic [11:0] rv;
    logic [31:0] rd1, rd2;
    pv[0] = 16'h1111; pv[1] = 16'h2222; pv[2] = 16'h3333; pv[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); pre_we = 1'b1; pre_addr = 6'(i); pre_data = pv[i];
    end
    @(negedge clk); pre_we = 1'b0;
    // The acceptance cycle in IDLE also shows ready low, ahead of the four access cycles.
    @(negedge clk); r_en = 1'b1; addr = 32'd1024; #1; rv[11] = ready;
    for (int i = 1; i <= 4; i++) begin @(negedge clk); #1; rv[11-i] = ready; end
    @(negedge clk); addr = 32'd1028; #1; rv[6] = ready; rd1 = rd_data;
    @(negedge clk); #1; rv[5] = ready;
    for (int i = 1; i <= 4; i++) begin @(negedge clk); #1; rv[5-i] = ready; end
    @(negedge clk); r_en = 1'b0; #1; rv[0] = ready; rd2 = rd_data;
    checks++; if (rv !== 12'b0000_0100_0001) begin errors++; $display("FAIL b2b_ready_pattern: got %b expected 000001000001", rv); end
    checks++; if (rd1 !== 32'h22221111) begin errors++; $display("FAIL b2b_first_read: got %h expected 22221111", rd1); end
    checks++; if (rd2 !== 32'h44443333) begin errors++; $display("FAIL b2b_second_read: got %h expected 44443333", rd2); end
  endtask

  task automatic test_simultaneous;
    logic [4:1] oe_v, dqoe_v;
    @(negedge clk); r_en = 1'b1; w_en = 1'b1; addr = 32'd1036; wr_data = 32'hCAFEF00D; #1;
    for (int i = 1; i <= 4; i++) begin @(negedge clk); #1; oe_v[i] = oe_n; dqoe_v[i] = dq_oe; end
    checks++; if ({oe_v, dqoe_v} !== 8'hFF) begin errors++; $display("FAIL both_req_is_write: got %b %b expected 1111 1111", oe_v, dqoe_v); end
    @(negedge clk); r_en = 1'b0; w_en = 1'b0; #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL both_req_done: got %b expected 1", ready); end
    checks++; if (mem[6] !== 16'hF00D || mem[7] !== 16'hCAFE) begin errors++; $display("FAIL both_req_sram: got %h %h expected f00d cafe", mem[6], mem[7]); end
    checks++; if (rd_data !== 32'h44443333) begin errors++; $display("FAIL both_req_rd_data: got %h expected 44443333", rd_data); end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk); w_en = 1'b1; addr = 32'd1040; wr_data = 32'h12345678; #1;
    for (int i = 1; i <= 3; i++) @(negedge clk);
    @(negedge clk); rst = 1'b1; w_en = 1'b0; #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready_during: got %b expected 1", ready); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (u_dut.state_q !== S_IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d expected %0d", u_dut.state_q, S_IDLE); end
    checks++; if ({we_n, dq_oe, ready} !== 3'b101) begin errors++; $display("FAIL rst_mid_outputs: got %b expected 101", {we_n, dq_oe, ready}); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rst_mid_rd_data: got %h expected 0", rd_data); end
    checks++; if (mem[8] !== 16'h5678) begin errors++; $display("FAIL rst_mid_partial_lo: got %h expected 5678", mem[8]); end
    @(negedge clk); r_en = 1'b1; addr = 32'd1032; #1;
    for (int i = 1; i <= 4; i++) @(negedge clk);
    @(negedge clk); r_en = 1'b0; #1;
    checks++; if (ready !== 1'b1 || rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_mid_recover: got %b %h expected 1 deadbeef", ready, rd_data); end
  endtask

  task automatic test_access4;
    logic [8:1]  rv;
    logic [31:0] rd_c4, rd_c5;
    logic [17:0] a_c1, a_c5;
    logic [3:0]  ctl_c2;
    logic [15:0] dqo_c2;
    @(negedge clk); r_en4 = 1'b1; addr4 = 32'd1024; dq_in4 = 16'h0A00; #1;
    checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL ac4_accept_ready: got %b expected 0", ready4); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); dq_in4 = 16'h0A00 + 16'(i); #1;
      rv[i] = ready4;
      if (i == 1) a_c1 = sram_addr4;
      if (i == 2) begin ctl_c2 = {oe_n4, we_n4, dq_oe4, 1'b0}; dqo_c2 = dq_out4; end
      if (i == 4) rd_c4 = rd_data4;
      if (i == 5) begin rd_c5 = rd_data4; a_c5 = sram_addr4; end
    end
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL ac4_ready_low8: got %b expected 00000000", rv); end
    checks++; if (a_c1 !== 18'd0 || a_c5 !== 18'd1) begin errors++; $display("FAIL ac4_sram_addr: got %0d/%0d expected 0/1", a_c1, a_c5); end
    checks++; if (ctl_c2 !== 4'b0100 || dqo_c2 !== 16'h0) begin errors++; $display("FAIL ac4_read_ctl: got %b %h expected 0100 0000", ctl_c2, dqo_c2); end
    checks++; if (rd_c4 !== 32'h0 || rd_c5 !== 32'h00000A04) begin errors++; $display("FAIL ac4_lo_sample: got %h/%h expected 00000000/00000a04", rd_c4, rd_c5); end
    @(negedge clk); r_en4 = 1'b0; #1;
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL ac4_done_ready: got %b expected 1", ready4); end
    checks++; if (rd_data4 !== 32'h0A080A04) begin errors++; $display("FAIL ac4_rd_data: got %h expected 0a080a04", rd_data4); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_access();
    test_access4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
